// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared definitions for the round-robin / addressed demux
//               family: mode encodings, default word width and the
//               explicit-wrap pointer successor used by rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam logic MODE_RR   = 1'b0;  // route to the round-robin pointer
  localparam logic MODE_ADDR = 1'b1;  // route to the channel named by sel_in

  localparam int DEMUX_W = 4;

  // Successor of ptr in a modulo-n sequence. The wrap is an explicit compare,
  // not a power-of-two rollover, so unused codes are never reached.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_rr_n_rr_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rr_ptr
// Description : Wrapping modulo-N counter with enable and synchronous clear.
//               Clear wins over enable.
// Ports       : clk     - rising-edge clock
//               reset_L - asynchronous active-low reset (ptr -> 0)
//               en      - advance the pointer by one (with wrap)
//               clr     - synchronous return of the pointer to 0
//               ptr     - current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module rr_ptr
  import demux_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          en,
  input  logic          clr,
  output logic [SW-1:0] ptr
);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= SW'(ptr_next(32'(ptr), N));
    end
  end

endmodule : rr_ptr
`default_nettype wire

// File: rtl/demux_rr_n.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_n
// Description : 1-to-N registered demultiplexer. Each valid input word is
//               written to one channel register, chosen either by an
//               internal round-robin pointer (mode 0) or by sel_in (mode 1).
//               Every channel holds its last word; valid_out is a one-cycle
//               one-hot strobe on the channel just written.
// Ports       : clk       - rising-edge clock
//               reset_L   - asynchronous active-low reset
//               valid_in  - data_in carries a word this cycle
//               data_in   - input word (W bits)
//               mode      - 0 round-robin, 1 addressed
//               sel_in    - target channel in addressed mode
//               clr_ptr   - synchronous clear of the round-robin pointer
//               data_out  - N*W bits, channel k at [k*W +: W]
//               valid_out - one-hot write strobe
//               ch_ptr    - next channel for round-robin
//               err_sel   - pulse: addressed word with sel_in >= N dropped
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_n
  import demux_pkg::*;
#(
  parameter int W  = DEMUX_W,
  parameter int N  = 2,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            valid_in,
  input  logic [W-1:0]    data_in,
  input  logic            mode,
  input  logic [SW-1:0]   sel_in,
  input  logic            clr_ptr,
  output logic [N*W-1:0]  data_out,
  output logic [N-1:0]    valid_out,
  output logic [SW-1:0]   ch_ptr,
  output logic            err_sel
);

  localparam int unsigned N_U = N;

  logic           wr_rr;
  logic           wr_addr;
  logic           drop;
  logic [N-1:0]   hit;
  logic [W-1:0]   ch_q [N];

  assign wr_rr   = valid_in && (mode == MODE_RR);
  assign wr_addr = valid_in && (mode == MODE_ADDR) && (32'(sel_in) <  N_U);
  assign drop    = valid_in && (mode == MODE_ADDR) && (32'(sel_in) >= N_U);

  // At most one bit is set: round-robin and addressed writes are exclusive
  // by mode, and each compares against a single channel index.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) begin
      if ((wr_rr && (ch_ptr == SW'(k))) || (wr_addr && (sel_in == SW'(k)))) begin
        hit[k] = 1'b1;
      end
    end
  end

  rr_ptr #(
    .N  (N),
    .SW (SW)
  ) u_rr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .en      (wr_rr),
    .clr     (clr_ptr),
    .ptr     (ch_ptr)
  );

  for (genvar k = 0; k < N; k++) begin : g_ch
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        ch_q[k] <= '0;
      end else if (hit[k]) begin
        ch_q[k] <= data_in;
      end
    end
    assign data_out[k*W +: W] = ch_q[k];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out <= '0;
      err_sel   <= 1'b0;
    end else begin
      valid_out <= hit;
      err_sel   <= drop;
    end
  end

endmodule : demux_rr_n
`default_nettype wire

// File: tb/tb_demux_rr_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_n
// Description : Self-checking bench for demux_rr_n. Two instances share one
//               stimulus stream: N=3/W=8 (non-power-of-two, out-of-range
//               selects possible) and N=4/W=4 (low data nibble). A
//               behavioural model with per-channel arrays and modulo
//               arithmetic predicts every output after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_n;

  logic        clk;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        mode;
  logic [1:0]  sel_in;
  logic        clr_ptr;

  logic [23:0] data_out3;
  logic [2:0]  valid_out3;
  logic [1:0]  ch_ptr3;
  logic        err_sel3;
  logic [15:0] data_out4;
  logic [3:0]  valid_out4;
  logic [1:0]  ch_ptr4;
  logic        err_sel4;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: channel contents, pointer, strobe and error flag.
  int          nch [2] = '{3, 4};
  logic [7:0]  m_data  [2][4];
  logic [3:0]  m_valid [2];
  int          m_ptr   [2];
  logic        m_err   [2];

  demux_rr_n #(.W(8), .N(3)) dut3 (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .mode      (mode),
    .sel_in    (sel_in),
    .clr_ptr   (clr_ptr),
    .data_out  (data_out3),
    .valid_out (valid_out3),
    .ch_ptr    (ch_ptr3),
    .err_sel   (err_sel3)
  );

  demux_rr_n #(.W(4), .N(4)) dut4 (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in[3:0]),
    .mode      (mode),
    .sel_in    (sel_in),
    .clr_ptr   (clr_ptr),
    .data_out  (data_out4),
    .valid_out (valid_out4),
    .ch_ptr    (ch_ptr4),
    .err_sel   (err_sel4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_data[i][k] = '0;
      m_valid[i] = '0;
      m_ptr[i]   = 0;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic model_update(input int i);
    logic [7:0] din;
    int         ch;
    din = (i == 1) ? {4'h0, data_in[3:0]} : data_in;
    m_valid[i] = '0;
    m_err[i]   = 1'b0;
    if (valid_in) begin
      if (mode == 1'b0) begin
        ch = m_ptr[i];
        m_data[i][ch] = din;
        m_valid[i]    = 4'(1 << ch);
        m_ptr[i]      = (m_ptr[i] + 1) % nch[i];
      end else if (int'(sel_in) < nch[i]) begin
        m_data[i][sel_in] = din;
        m_valid[i]        = 4'(1 << sel_in);
      end else begin
        m_err[i] = 1'b1;
      end
    end
    if (clr_ptr) m_ptr[i] = 0;
  endtask

  task automatic compare_all();
    check("d3_data",  32'(data_out3),
          32'({m_data[0][2], m_data[0][1], m_data[0][0]}));
    check("d3_valid", 32'(valid_out3), 32'(m_valid[0][2:0]));
    check("d3_ptr",   32'(ch_ptr3),    32'(m_ptr[0]));
    check("d3_err",   32'(err_sel3),   32'(m_err[0]));
    check("d4_data",  32'(data_out4),
          32'({m_data[1][3][3:0], m_data[1][2][3:0], m_data[1][1][3:0], m_data[1][0][3:0]}));
    check("d4_valid", 32'(valid_out4), 32'(m_valid[1]));
    check("d4_ptr",   32'(ch_ptr4),    32'(m_ptr[1]));
    check("d4_err",   32'(err_sel4),   32'(m_err[1]));
  endtask

  // One clock: model advances on the edge, outputs compared mid-low-phase.
  task automatic step();
    @(posedge clk);
    if (!reset_L) model_reset();
    else for (int i = 0; i < 2; i++) model_update(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic m,
                       input logic [1:0] s, input logic c);
    valid_in = v;
    data_in  = d;
    mode     = m;
    sel_in   = s;
    clr_ptr  = c;
    step();
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    mode     = 1'b0;
    sel_in   = '0;
    clr_ptr  = 1'b0;
    model_reset();

    // Held in reset while the input toggles: nothing may leak through.
    drive(1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h0F, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h0A, 1'b1, 2'd1, 1'b0);
    reset_L = 1'b1;

    // Round-robin with a bubble; N=3 wraps back to channel 0.
    drive(1'b1, 8'h11, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 8'hEE, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 2'd0, 1'b0);
    check("rr_wrap_data3", 32'(data_out3), 32'h0033_2244);
    check("rr_wrap_ptr3",  32'(ch_ptr3),   32'd1);

    // Addressed: in-range write, then an out-of-range select on N=3.
    drive(1'b1, 8'hA5, 1'b1, 2'd2, 1'b0);
    check("addr_valid3", 32'(valid_out3), 32'b100);
    drive(1'b1, 8'h5A, 1'b1, 2'd3, 1'b0);
    check("addr_err3",   32'(err_sel3),   32'd1);
    check("addr_drop3",  32'(data_out3),  32'h00A5_2244);

    // Move N=3 pointer to 2, then write with clr_ptr asserted.
    drive(1'b1, 8'h77, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 8'h09, 1'b0, 2'd0, 1'b1);
    check("clr_valid3", 32'(valid_out3), 32'b100);
    check("clr_ptr3",   32'(ch_ptr3),    32'd0);
    drive(1'b1, 8'h0D, 1'b0, 2'd0, 1'b0);
    check("after_clr3", 32'(valid_out3), 32'b001);

    // Asynchronous reset in the middle of a valid cycle.
    valid_in = 1'b1;
    data_in  = 8'h05;
    mode     = 1'b0;
    clr_ptr  = 1'b0;
    step();
    valid_in = 1'b1;
    data_in  = 8'h0C;
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    reset_L = 1'b1;
    drive(1'b1, 8'h06, 1'b0, 2'd0, 1'b0);
    check("post_rst_valid3", 32'(valid_out3), 32'b001);
    check("post_rst_ptr3",   32'(ch_ptr3),    32'd1);
    check("post_rst_data4",  32'(data_out4),  32'h0006);

    // Randomised traffic against the model.
    for (int t = 0; t < 400; t++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_demux_rr_n
`default_nettype wire
